// File: rtl/decode_pkg.sv
// Shared decode definitions: opcode map, instruction field positions and the
// registered decode bundle handed to execute.
package decode_pkg;

  localparam logic [5:0] OP_ADD  = 6'b110001;
  localparam logic [5:0] OP_LDW  = 6'b010111;
  localparam logic [5:0] OP_MUL  = 6'b100111;
  localparam logic [5:0] OP_BLT  = 6'b010110;
  localparam logic [5:0] OP_STW  = 6'b010101;
  localparam logic [5:0] OP_BR   = 6'b000110;
  localparam logic [5:0] OP_ADDI = 6'b000100;
  localparam logic [5:0] OP_BEQ  = 6'b100110;
  localparam logic [5:0] OP_BNE  = 6'b011110;
  localparam logic [5:0] OP_JMP  = 6'b111010;
  localparam logic [5:0] OP_CALL = 6'b000000;
  localparam logic [5:0] OP_SUBI = 6'b011111;
  localparam logic [5:0] OP_NOPE = 6'b111111;

  localparam logic [5:0] LINK_REG = 6'd31;

  localparam int OP_LSB  = 0;
  localparam int A_LSB   = 27;
  localparam int B_LSB   = 22;
  localparam int C_LSB   = 17;
  localparam int IMM_LSB = 6;

  typedef struct packed {
    logic [5:0]  opcode;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sign_ext;
    logic [5:0]  src_reg;
    logic [5:0]  targ_reg;
    logic [5:0]  dest_reg;
  } decode_out_t;

  // NOPE itself is treated as "not a real instruction" by the decoder.
  function automatic logic is_real_op(input logic [5:0] op);
    case (op)
      OP_ADD, OP_LDW, OP_MUL, OP_BLT, OP_STW, OP_BR, OP_ADDI,
      OP_BEQ, OP_BNE, OP_JMP, OP_CALL, OP_SUBI: is_real_op = 1'b1;
      default:                                  is_real_op = 1'b0;
    endcase
  endfunction

  function automatic logic reads_b(input logic [5:0] op);
    case (op)
      OP_ADD, OP_MUL, OP_STW, OP_BEQ, OP_BNE, OP_BLT: reads_b = 1'b1;
      default:                                        reads_b = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/decode_regfile.sv
// 32x32 register file: two async read ports with writeback bypass, one sync
// write port, r0 hardwired to zero, indices >= 32 on the write port dropped.
module regfile_40
  import decode_pkg::*;
(
  input  logic        clk_40,
  input  logic        rst_40,
  input  logic [4:0]  rd_a_addr,
  input  logic [4:0]  rd_b_addr,
  output logic [31:0] rd_a_data,
  output logic [31:0] rd_b_data,
  input  logic        wr_en,
  input  logic [5:0]  wr_addr,
  input  logic [31:0] wr_data
);

  logic [31:0] regs [32];
  logic        wr_hit;

  assign wr_hit = wr_en && !wr_addr[5] && (wr_addr[4:0] != 5'd0);

  always_ff @(posedge clk_40 or negedge rst_40) begin
    if (!rst_40) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wr_hit) begin
      regs[wr_addr[4:0]] <= wr_data;
    end
  end

  // Same-cycle writeback is forwarded so decode never sees a stale value.
  always_comb begin
    rd_a_data = '0;
    if (rd_a_addr != 5'd0) begin
      if (wr_hit && wr_addr[4:0] == rd_a_addr) rd_a_data = wr_data;
      else                                     rd_a_data = regs[rd_a_addr];
    end
  end

  always_comb begin
    rd_b_data = '0;
    if (rd_b_addr != 5'd0) begin
      if (wr_hit && wr_addr[4:0] == rd_b_addr) rd_b_data = wr_data;
      else                                     rd_b_data = regs[rd_b_addr];
    end
  end

endmodule

// File: rtl/decode.sv
// Decode / register-read stage: field extraction, operand read, load-use
// hazard detection and the output register feeding execute.
module decode
  import decode_pkg::*;
#(
  parameter logic [5:0] NOPE_OP = OP_NOPE,
  parameter logic [5:0] RA_REG  = LINK_REG
) (
  input  logic        clk_40,
  input  logic        rst_40,
  input  logic [31:0] instr_40,
  input  logic [31:0] pc_40,
  input  logic        instr_valid_40,
  input  logic        flush_40,
  input  logic        wb_en_40,
  input  logic [5:0]  wb_reg_40,
  input  logic [31:0] wb_data_40,
  output logic        stall_40,
  output logic [5:0]  opcode_40,
  output logic [31:0] a_40,
  output logic [31:0] b_40,
  output logic [31:0] sign_ext_40,
  output logic [5:0]  src_reg_40,
  output logic [5:0]  targ_reg_40,
  output logic [5:0]  dest_reg_40
);

  logic [5:0]  op;
  logic [4:0]  fa, fb, fc;
  logic [15:0] imm16;
  logic [31:0] rf_a, rf_b;
  logic        hazard;
  decode_out_t cur_q, nxt;

  assign op    = instr_40[OP_LSB +: 6];
  assign fa    = instr_40[A_LSB +: 5];
  assign fb    = instr_40[B_LSB +: 5];
  assign fc    = instr_40[C_LSB +: 5];
  assign imm16 = instr_40[IMM_LSB +: 16];

  regfile_40 u_regfile (
    .clk_40    (clk_40),
    .rst_40    (rst_40),
    .rd_a_addr (fa),
    .rd_b_addr (fb),
    .rd_a_data (rf_a),
    .rd_b_data (rf_b),
    .wr_en     (wb_en_40),
    .wr_addr   (wb_reg_40),
    .wr_data   (wb_data_40)
  );

  // The last issued instruction is the output register itself; a bubble
  // issues NOPE, so the hazard clears on its own one cycle later.
  always_comb begin
    hazard = 1'b0;
    if (instr_valid_40 && cur_q.opcode == OP_LDW && cur_q.dest_reg != 6'd0) begin
      if ({1'b0, fa} == cur_q.dest_reg)                 hazard = 1'b1;
      if (reads_b(op) && {1'b0, fb} == cur_q.dest_reg)  hazard = 1'b1;
    end
  end

  assign stall_40 = hazard && !flush_40;

  always_comb begin
    nxt        = '0;
    nxt.opcode = NOPE_OP;
    if (instr_valid_40 && !flush_40 && !hazard && is_real_op(op)) begin
      nxt.opcode   = op;
      nxt.a        = rf_a;
      nxt.b        = rf_b;
      nxt.sign_ext = {{16{imm16[15]}}, imm16};
      nxt.src_reg  = {1'b0, fa};
      nxt.targ_reg = {1'b0, fb};
      case (op)
        OP_ADD, OP_MUL:           nxt.dest_reg = {1'b0, fc};
        OP_ADDI, OP_SUBI, OP_LDW: nxt.dest_reg = {1'b0, fb};
        OP_CALL: begin
          nxt.dest_reg = RA_REG;
          nxt.b        = pc_40 + 32'd4;
        end
        default:                  nxt.dest_reg = 6'd0;
      endcase
    end
  end

  always_ff @(posedge clk_40 or negedge rst_40) begin
    if (!rst_40) begin
      cur_q        <= '0;
      cur_q.opcode <= NOPE_OP;
    end else begin
      cur_q <= nxt;
    end
  end

  assign opcode_40   = cur_q.opcode;
  assign a_40        = cur_q.a;
  assign b_40        = cur_q.b;
  assign sign_ext_40 = cur_q.sign_ext;
  assign src_reg_40  = cur_q.src_reg;
  assign targ_reg_40 = cur_q.targ_reg;
  assign dest_reg_40 = cur_q.dest_reg;

endmodule

// File: tb/tb_decode.sv
// Directed bench for decode: reset, operand read, bypass, load-use stall,
// flush priority, CALL link value and unknown-opcode handling.
module tb_decode;

  logic        clk_40 = 1'b0;
  logic        rst_40;
  logic [31:0] instr_40;
  logic [31:0] pc_40;
  logic        instr_valid_40;
  logic        flush_40;
  logic        wb_en_40;
  logic [5:0]  wb_reg_40;
  logic [31:0] wb_data_40;
  logic        stall_40;
  logic [5:0]  opcode_40;
  logic [31:0] a_40, b_40, sign_ext_40;
  logic [5:0]  src_reg_40, targ_reg_40, dest_reg_40;

  int total = 0;
  int bad   = 0;

  always #5 clk_40 = ~clk_40;

  decode dut (
    .clk_40         (clk_40),
    .rst_40         (rst_40),
    .instr_40       (instr_40),
    .pc_40          (pc_40),
    .instr_valid_40 (instr_valid_40),
    .flush_40       (flush_40),
    .wb_en_40       (wb_en_40),
    .wb_reg_40      (wb_reg_40),
    .wb_data_40     (wb_data_40),
    .stall_40       (stall_40),
    .opcode_40      (opcode_40),
    .a_40           (a_40),
    .b_40           (b_40),
    .sign_ext_40    (sign_ext_40),
    .src_reg_40     (src_reg_40),
    .targ_reg_40    (targ_reg_40),
    .dest_reg_40    (dest_reg_40)
  );

  function automatic logic [31:0] mk_r(input logic [5:0] op, input logic [4:0] a,
                                       input logic [4:0] b, input logic [4:0] c);
    mk_r = {a, b, c, 11'b0, op};
  endfunction

  function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [4:0] a,
                                       input logic [4:0] b, input logic [15:0] imm);
    mk_i = {a, b, imm, op};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock and land 1ns after the rising edge.
  task automatic tick();
    @(posedge clk_40);
    #1;
  endtask

  task automatic wb(input logic [5:0] r, input logic [31:0] d);
    wb_en_40 = 1'b1; wb_reg_40 = r; wb_data_40 = d;
  endtask

  task automatic wb_off();
    wb_en_40 = 1'b0; wb_reg_40 = '0; wb_data_40 = '0;
  endtask

  task automatic issue(input logic [31:0] ins);
    instr_40 = ins; instr_valid_40 = 1'b1;
  endtask

  task automatic chk_nope(input string tag);
    chk({tag, "_op"},   {26'b0, opcode_40}, 32'h3F);
    chk({tag, "_a"},    a_40, 32'h0);
    chk({tag, "_b"},    b_40, 32'h0);
    chk({tag, "_se"},   sign_ext_40, 32'h0);
    chk({tag, "_dest"}, {26'b0, dest_reg_40}, 32'h0);
  endtask

  initial begin
    rst_40 = 1'b0; instr_40 = '0; pc_40 = '0; instr_valid_40 = 1'b0;
    flush_40 = 1'b0;
    wb_off();
    repeat (3) tick();
    chk_nope("reset");
    chk("reset_stall", {31'b0, stall_40}, 32'h0);
    chk("reset_src", {26'b0, src_reg_40}, 32'h0);
    rst_40 = 1'b1;

    // Load r1=10, r2=0x100, r4=0x44, r6=0x66.
    wb(6'd1, 32'd10);    tick();
    wb(6'd2, 32'h100);   tick();
    wb(6'd4, 32'h44);    tick();
    wb(6'd6, 32'h66);    tick();
    wb_off();

    // ADDI r3, r1, -4
    issue(mk_i(6'b000100, 5'd1, 5'd3, 16'hFFFC)); tick();
    chk("addi_op",   {26'b0, opcode_40}, 32'h04);
    chk("addi_a",    a_40, 32'd10);
    chk("addi_b",    b_40, 32'd0);
    chk("addi_se",   sign_ext_40, 32'hFFFF_FFFC);
    chk("addi_src",  {26'b0, src_reg_40}, 32'd1);
    chk("addi_targ", {26'b0, targ_reg_40}, 32'd3);
    chk("addi_dest", {26'b0, dest_reg_40}, 32'd3);

    // BR with positive immediate: dest 0.
    issue(mk_i(6'b000110, 5'd2, 5'd1, 16'h7FFF)); tick();
    chk("br_op",   {26'b0, opcode_40}, 32'h06);
    chk("br_se",   sign_ext_40, 32'h0000_7FFF);
    chk("br_dest", {26'b0, dest_reg_40}, 32'd0);
    chk("br_a",    a_40, 32'h100);

    // Bypass: r5 written the same cycle ADD r7, r5, r6 reads it.
    wb(6'd5, 32'h1234);
    issue(mk_r(6'b110001, 5'd5, 5'd6, 5'd7)); tick();
    chk("byp_a",    a_40, 32'h1234);
    chk("byp_b",    b_40, 32'h66);
    chk("byp_dest", {26'b0, dest_reg_40}, 32'd7);

    // Write to r0 ignored, even on the bypass path.
    wb(6'd0, 32'hDEAD_BEEF);
    issue(mk_r(6'b110001, 5'd0, 5'd5, 5'd9)); tick();
    chk("r0_byp_a", a_40, 32'h0);
    chk("r5_kept",  b_40, 32'h1234);
    // Index 37 aliases r5 in its low bits but must be dropped.
    wb(6'd37, 32'h0BAD);
    issue(mk_r(6'b100111, 5'd0, 5'd5, 5'd9)); tick();
    chk("r0_rf_a",  a_40, 32'h0);
    chk("wb37_byp", b_40, 32'h1234);
    wb_off();
    tick();
    chk("wb37_rf",  b_40, 32'h1234);

    // Load-use on A: LDW r4,0(r2) then ADD r8, r4, r1.
    issue(mk_i(6'b010111, 5'd2, 5'd4, 16'h0000)); tick();
    chk("ldw_op",   {26'b0, opcode_40}, 32'h17);
    chk("ldw_a",    a_40, 32'h100);
    chk("ldw_dest", {26'b0, dest_reg_40}, 32'd4);
    issue(mk_r(6'b110001, 5'd4, 5'd1, 5'd8)); #1;
    chk("lu_stall", {31'b0, stall_40}, 32'h1);
    tick();
    chk_nope("lu_bubble");
    chk("lu_stall_clr", {31'b0, stall_40}, 32'h0);
    tick();
    chk("lu_add_op",   {26'b0, opcode_40}, 32'h31);
    chk("lu_add_a",    a_40, 32'h44);
    chk("lu_add_b",    b_40, 32'd10);
    chk("lu_add_dest", {26'b0, dest_reg_40}, 32'd8);

    // Load-use on B via STW; ADDI with B==d does not read B.
    issue(mk_i(6'b010111, 5'd2, 5'd4, 16'h0000)); tick();
    issue(mk_i(6'b010101, 5'd1, 5'd4, 16'h0008)); #1;
    chk("lu_b_stall", {31'b0, stall_40}, 32'h1);
    issue(mk_i(6'b000100, 5'd1, 5'd4, 16'h0001)); #1;
    chk("lu_addi_nostall", {31'b0, stall_40}, 32'h0);
    tick();
    chk("lu_addi_op", {26'b0, opcode_40}, 32'h04);

    // LDW into r0 never causes a stall.
    issue(mk_i(6'b010111, 5'd2, 5'd0, 16'h0000)); tick();
    issue(mk_r(6'b110001, 5'd0, 5'd0, 5'd8)); #1;
    chk("ldw_r0_nostall", {31'b0, stall_40}, 32'h0);

    // Flush wins over hazard.
    issue(mk_i(6'b010111, 5'd2, 5'd4, 16'h0000)); tick();
    issue(mk_r(6'b110001, 5'd4, 5'd1, 5'd8)); flush_40 = 1'b1; #1;
    chk("flush_stall", {31'b0, stall_40}, 32'h0);
    tick();
    chk_nope("flush");
    flush_40 = 1'b0;

    // CALL at the top of the address space: link value wraps to 0.
    pc_40 = 32'hFFFF_FFFC;
    issue(mk_i(6'b000000, 5'd1, 5'd2, 16'h0010)); tick();
    chk("call_op",   {26'b0, opcode_40}, 32'h00);
    chk("call_a",    a_40, 32'd10);
    chk("call_b",    b_40, 32'h0);
    chk("call_dest", {26'b0, dest_reg_40}, 32'd31);
    pc_40 = '0;

    // Unknown opcode and invalid slot both issue a clean NOPE.
    issue(mk_r(6'b101010, 5'd1, 5'd2, 5'd3)); tick();
    chk_nope("unknown");
    issue(mk_r(6'b110001, 5'd1, 5'd2, 5'd3)); instr_valid_40 = 1'b0; tick();
    chk_nope("invalid");

    // Reset in the middle of a stall.
    issue(mk_i(6'b010111, 5'd2, 5'd4, 16'h0000)); tick();
    issue(mk_r(6'b110001, 5'd4, 5'd1, 5'd8)); #1;
    chk("mid_stall", {31'b0, stall_40}, 32'h1);
    rst_40 = 1'b0; #1;
    chk("mid_rst_stall", {31'b0, stall_40}, 32'h0);
    chk_nope("mid_rst");
    tick();
    rst_40 = 1'b1;
    issue(mk_r(6'b110001, 5'd1, 5'd4, 5'd8)); tick();
    chk("post_rst_a", a_40, 32'h0);
    chk("post_rst_b", b_40, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decode.md
# decode

Instruction decode / register-read stage of the 5-stage pipeline; the producer side of the execute-stage operand interface. Takes a fetched 32-bit instruction and its PC, reads a 32×32 register file with writeback bypass, sign-extends the immediate, and registers opcode, operands and register indices for execute. Detects load-use hazards (inserts one NOPE bubble and stalls fetch) and honours branch flushes.

## Interface
- Parameters: NOPE_OP, 6'b111111, bubble opcode; RA_REG, 31, CALL link register
- clk_40  in  1  clock, all state on rising edge
- rst_40  in  1  reset, asynchronous, active-low
- instr_40  in  32  fetched instruction
- pc_40  in  32  byte address of instr_40
- instr_valid_40  in  1  instr_40 is a real instruction
- flush_40  in  1  squash the instruction currently in decode
- wb_en_40, wb_reg_40 [5:0], wb_data_40 [31:0]  in  writeback write port
- stall_40  out  1  hold fetch (fetch re-presents the same instr_40 next cycle)
- opcode_40  out  6  registered opcode to execute
- a_40, b_40, sign_ext_40  out  32 each  registered operands / immediate
- src_reg_40, targ_reg_40, dest_reg_40  out  6 each  registered register indices

## Operation
- Fields: op=instr[5:0], A=instr[31:27], B=instr[26:22], C=instr[21:17], imm16=instr[21:6]; 5-bit fields zero-extended to 6.
- Opcodes (shared package): ADD 110001, LDW 010111, MUL 100111, BLT 010110, STW 010101, BR 000110, ADDI 000100, BEQ 100110, BNE 011110, JMP 111010, CALL 000000, SUBI 011111, NOPE 111111.
- src_reg=A, targ_reg=B always; a=RF[A], b=RF[B]; sign_ext={{16{imm16[15]}},imm16}.
- dest_reg: ADD/MUL → C; ADDI/SUBI/LDW → B; CALL → RA_REG, b=pc_40+4 (wrap mod 2^32); all others → 0.
- Unrecognised opcode decoded as NOPE (all outputs except opcode as for NOPE: zero).
- Register file: r0 reads 0, writes to r0 ignored; wb_reg ≥32 ignored. Read of register being written same cycle returns wb_data_40 (bypass).
- Load-use hazard: previously issued opcode LDW with dest d≠0, and current valid instruction reads d (A==d, or B==d for ADD/MUL/STW/BEQ/BNE/BLT) → stall_40=1 combinationally, issue NOPE, latch nothing from instr_40. Next cycle hazard clears (last issued is NOPE).
- Priority: reset > flush > hazard > normal. flush_40=1 → issue NOPE, stall_40=0. instr_valid_40=0 → issue NOPE, stall_40=0.

## Timing
- Reset (async assert, sync release): opcode_40=NOPE, all other outputs 0, stall_40=0, all RF entries 0, last-issued tracker=NOPE.
- Latency 1 cycle: instruction sampled at edge N appears on outputs after edge N.
- Writeback at edge N visible to reads in cycle N (bypass) and thereafter (RF).
- Stall exactly one cycle per load-use pair; back-to-back LDW→dependent LDW→dependent stalls once per pair.
- Reset mid-stall: outputs return to reset values immediately; stall_40 drops.

## Structure
- Shared package decode_pkg (reused by execute): opcode constants, NOPE_OP, RA_REG, field bit positions.
- One sub-module: regfile_40 (32×32, 2 async read ports, 1 sync write port, r0 hardwired, bypass). Decode/hazard logic and output register in decode.

## Test plan
- Reset: assert rst_40=0 mid-run → opcode_40=111111, a/b/sign_ext=0, stall_40=0; RF reads 0 after release.
- ADDI r3,r1,-4 (imm16=0xFFFC) with RF[1]=10 → next cycle opcode_40=000100, a_40=10, sign_ext_40=0xFFFFFFFC, dest_reg_40=3.
- Bypass: wb_en=1, wb_reg=5, wb_data=0x1234 same cycle as ADD r7,r5,r6 decode → a_40=0x1234; wb_reg=0 write → r0 still reads 0.
- Load-use: LDW r4,0(r2) then ADD r8,r4,r1 → stall_40=1 one cycle, NOPE issued, then ADD issued with a_40=RF[4].
- Flush+hazard same cycle → NOPE issued, stall_40=0; CALL at pc=0xFFFFFFFC → b_40=0, dest_reg_40=31.
